// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the 32x8 data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port A always wins a tie.
module data_mem_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              A_Req,
  input  logic              A_We,
  input  logic [ADDR_W-1:0] A_Address,
  input  logic [DATA_W-1:0] A_Data_in,
  output logic              A_Ack,
  output logic [DATA_W-1:0] A_Data_out,
  input  logic              B_Req,
  input  logic              B_We,
  input  logic [ADDR_W-1:0] B_Address,
  input  logic [DATA_W-1:0] B_Data_in,
  output logic              B_Ack,
  output logic [DATA_W-1:0] B_Data_out,
  output logic              Mem_En,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_Data_in,
  input  logic [DATA_W-1:0] Mem_Data_out,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              a_win;
  logic              b_win;

  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    a_win = A_Req;
`else
    a_win = A_Req && (!B_Req || (last_grant == PORT_B));
`endif
    b_win = B_Req && !a_win;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_B;
      owner      <= PORT_A;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      A_Ack      <= 1'b0;
      B_Ack      <= 1'b0;
      A_Data_out <= '0;
      B_Data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_win) begin
            owner      <= PORT_A;
            last_grant <= PORT_A;
            lat_we     <= A_We;
            lat_addr   <= A_Address;
            lat_data   <= A_Data_in;
            state      <= ACCESS;
          end else if (b_win) begin
            owner      <= PORT_B;
            last_grant <= PORT_B;
            lat_we     <= B_We;
            lat_addr   <= B_Address;
            lat_data   <= B_Data_in;
            state      <= ACCESS;
          end
        end
        // memory sees the access this cycle; read data is captured at its end
        ACCESS: begin
          if (owner == PORT_A) begin
            A_Ack <= 1'b1;
            if (!lat_we) A_Data_out <= Mem_Data_out;
          end else begin
            B_Ack <= 1'b1;
            if (!lat_we) B_Data_out <= Mem_Data_out;
          end
          state <= DONE;
        end
        DONE: begin
          A_Ack <= 1'b0;
          B_Ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // memory pins decode from registered state only, so they drop with async reset
  assign Mem_En      = (state == ACCESS) && lat_we;
  assign Mem_Address = (state == ACCESS) ? lat_addr : '0;
  assign Mem_Data_in = (state == ACCESS) ? lat_data : '0;
  assign Busy        = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scoreboard bench for data_mem_arbiter with a behavioural 32x8 memory.
module tb_data_mem_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              A_Req, A_We, B_Req, B_We;
  logic [ADDR_W-1:0] A_Address, B_Address;
  logic [DATA_W-1:0] A_Data_in, B_Data_in;
  logic              A_Ack, B_Ack;
  logic [DATA_W-1:0] A_Data_out, B_Data_out;
  logic              Mem_En, Busy;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_Data_in, Mem_Data_out;

  always #5 Clk = ~Clk;

  data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_Req(A_Req), .A_We(A_We), .A_Address(A_Address), .A_Data_in(A_Data_in),
    .A_Ack(A_Ack), .A_Data_out(A_Data_out),
    .B_Req(B_Req), .B_We(B_We), .B_Address(B_Address), .B_Data_in(B_Data_in),
    .B_Ack(B_Ack), .B_Data_out(B_Data_out),
    .Mem_En(Mem_En), .Mem_Address(Mem_Address), .Mem_Data_in(Mem_Data_in),
    .Mem_Data_out(Mem_Data_out), .Busy(Busy)
  );

  logic [DATA_W-1:0] mem [32];
  always @(posedge Clk) if (Mem_En) mem[Mem_Address] <= Mem_Data_in;
  assign Mem_Data_out = mem[Mem_Address];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit                port;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t q[$];

  logic [DATA_W-1:0] ref_mem [32];
  logic [DATA_W-1:0] ref_a, ref_b;
  int tests = 0;
  int fails = 0;
  int ack_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    A_Req = 1'b0; A_We = 1'b0; A_Address = '0; A_Data_in = '0;
    B_Req = 1'b0; B_We = 1'b0; B_Address = '0; B_Data_in = '0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    ref_a = '0;
    ref_b = '0;
    q.delete();
  endtask

  task automatic drive(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] d);
    if (port) begin
      B_Req = 1'b1; B_We = we; B_Address = addr; B_Data_in = d;
    end else begin
      A_Req = 1'b1; A_We = we; A_Address = addr; A_Data_in = d;
    end
  endtask

  // Push in the order the accesses are expected to complete.
  task automatic expect_access(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] d);
    exp_t e;
    e.port = port;
    if (we) ref_mem[addr] = d;
    else if (port) ref_b = ref_mem[addr];
    else ref_a = ref_mem[addr];
    e.data = port ? ref_b : ref_a;
    q.push_back(e);
  endtask

  task automatic wait_ack(input string tag, input bit drop);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge Clk);
      if (A_Ack || B_Ack) seen = 1'b1;
    end
    check({tag, " ack seen"}, 32'(seen), 32'(1));
    if (!seen) return;
    ack_cyc = cyc;
    check({tag, " single ack"}, 32'(A_Ack && B_Ack), 32'(0));
    check({tag, " queued"}, 32'(q.size() != 0), 32'(1));
    if (q.size() == 0) return;
    e = q.pop_front();
    check({tag, " port"}, 32'(B_Ack), 32'(e.port));
    check({tag, " data"}, 32'(e.port ? B_Data_out : A_Data_out), 32'(e.data));
    if (drop) begin
      if (e.port) B_Req = 1'b0;
      else A_Req = 1'b0;
    end
  endtask

  task automatic do_access(input string tag, input bit port, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    @(negedge Clk);
    drive(port, we, addr, d);
    expect_access(port, we, addr, d);
    wait_ack(tag, 1'b1);
    @(negedge Clk);
    check({tag, " ack pulse"}, 32'(A_Ack | B_Ack), 32'(0));
  endtask

  initial begin
    int a_first;
    do_reset();
    check("rst A_Ack", 32'(A_Ack), 32'(0));
    check("rst B_Ack", 32'(B_Ack), 32'(0));
    check("rst A_Data_out", 32'(A_Data_out), 32'(0));
    check("rst B_Data_out", 32'(B_Data_out), 32'(0));
    check("rst Busy", 32'(Busy), 32'(0));
    check("rst Mem_En", 32'(Mem_En), 32'(0));

    // A write with cycle-level timing
    @(negedge Clk);
    drive(1'b0, 1'b1, 5'h03, 8'hA5);
    expect_access(1'b0, 1'b1, 5'h03, 8'hA5);
    @(negedge Clk);
    check("wr Mem_En", 32'(Mem_En), 32'(1));
    check("wr Mem_Address", 32'(Mem_Address), 32'h03);
    check("wr Mem_Data_in", 32'(Mem_Data_in), 32'hA5);
    check("wr Busy", 32'(Busy), 32'(1));
    check("wr early ack", 32'(A_Ack), 32'(0));
    wait_ack("wr", 1'b1);
    check("wr Mem_En in DONE", 32'(Mem_En), 32'(0));
    @(negedge Clk);
    check("wr ack pulse", 32'(A_Ack), 32'(0));
    check("wr idle Mem_Address", 32'(Mem_Address), 32'(0));

    // preload through port B
    do_access("pre00", 1'b1, 1'b1, 5'h00, 8'h11);
    do_access("pre1F", 1'b1, 1'b1, 5'h1F, 8'h22);

    // first tie after reset goes to A
    do_reset();
    @(negedge Clk);
    drive(1'b0, 1'b0, 5'h00, 8'h00);
    drive(1'b1, 1'b0, 5'h1F, 8'h00);
    expect_access(1'b0, 1'b0, 5'h00, 8'h00);
    expect_access(1'b1, 1'b0, 5'h1F, 8'h00);
    wait_ack("tieA", 1'b1);
    a_first = ack_cyc;
    wait_ack("tieB", 1'b1);
    check("tie B spacing", 32'(ack_cyc - a_first), 32'(3));

    do_access("rdA03", 1'b0, 1'b0, 5'h03, 8'h00);

    // cross-port write then read
    do_access("xB wr", 1'b1, 1'b1, 5'h1F, 8'h5C);
    do_access("xA rd", 1'b0, 1'b0, 5'h1F, 8'h00);
    check("x B_Data_out held", 32'(B_Data_out), 32'h22);

    // continuous requests on both ports
    do_reset();
    @(negedge Clk);
    drive(1'b0, 1'b0, 5'h03, 8'h00);
    drive(1'b1, 1'b0, 5'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      expect_access(1'b0, 1'b0, 5'h03, 8'h00);
`else
      expect_access(1'(i % 2), 1'b0, (i % 2) ? 5'h00 : 5'h03, 8'h00);
`endif
    end
    for (int i = 0; i < 6; i++) wait_ack($sformatf("rr%0d", i), 1'b0);
    A_Req = 1'b0;
    B_Req = 1'b0;
    repeat (2) @(negedge Clk);
    check("rr idle Busy", 32'(Busy), 32'(0));

    // reset during ACCESS of a write
    do_access("pre07", 1'b1, 1'b1, 5'h07, 8'h3C);
    @(negedge Clk);
    drive(1'b0, 1'b1, 5'h07, 8'hFF);
    @(negedge Clk);
    check("mid Mem_En before", 32'(Mem_En), 32'(1));
    #1 Rst_n = 1'b0;
    #1;
    check("mid Mem_En", 32'(Mem_En), 32'(0));
    check("mid Busy", 32'(Busy), 32'(0));
    check("mid A_Ack", 32'(A_Ack), 32'(0));
    A_Req = 1'b0;
    @(negedge Clk);
    check("mid no ack", 32'(A_Ack), 32'(0));
    check("mid mem7", 32'(mem[7]), 32'h3C);
    Rst_n = 1'b1;
    ref_a = '0;
    ref_b = '0;
    q.delete();
    do_access("mid rd07", 1'b1, 1'b0, 5'h07, 8'h00);

    // Req withdrawn right after the grant
    @(negedge Clk);
    drive(1'b0, 1'b0, 5'h00, 8'h00);
    expect_access(1'b0, 1'b0, 5'h00, 8'h00);
    @(negedge Clk);
    A_Req = 1'b0;
    A_Address = 5'h1F;
    wait_ack("drop", 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check($sformatf("drop quiet%0d", i), 32'(A_Ack | B_Ack | Mem_En | Busy), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
